// File: rtl/rstack_lifo.sv
// Self-managed return-address LIFO that owns its own stack pointer.
// It has one write port and async top/peek reads, and tracks sticky overflow/underflow flags.
module rstack_lifo #(
    parameter int DATA_WIDTH = 13,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = 4,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] top,
    input  logic [IDX_WIDTH-1:0]  peek_idx,
    output logic [DATA_WIDTH-1:0] peek_data,
    output logic                  peek_valid,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (IDX_WIDTH > CNT_WIDTH) ? IDX_WIDTH : CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic                  is_empty, is_full;
    logic [AW-1:0]         top_slot;
    logic [CW-1:0]         idx_ext, cnt_ext, peek_pos;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // Operation decode in priority order; err_clr is applied first so a same-edge set wins.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                wr_addr = AW'(count_q);
                count_d = count_q + CNT_ONE;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop && !push) begin
            if (!is_empty) begin
                count_d = count_q - CNT_ONE;
            end else begin
                udf_d = 1'b1;
            end
        end else if (push && pop) begin
            if (!is_empty) begin
                wr_en   = 1'b1;
                wr_addr = AW'(count_q - CNT_ONE);
            end else begin
                // Replace on an empty stack flags underflow but still lands the push.
                udf_d   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = '0;
                count_d = CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately not reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= din;
        end
    end

    assign top_slot = AW'(count_q - CNT_ONE);
    assign idx_ext  = CW'(peek_idx);
    assign cnt_ext  = CW'(count_q);
    assign peek_pos = cnt_ext - CW'(1) - idx_ext;

    assign top        = is_empty ? '0 : mem_q[top_slot];
    assign peek_valid = (idx_ext < cnt_ext);
    assign peek_data  = peek_valid ? mem_q[AW'(peek_pos)] : '0;
    assign count      = count_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_rstack_lifo.sv
// Bench for rstack_lifo: directed scenarios followed by random traffic, all compared
// against a queue-based stack model held in the bench.
module tb_rstack_lifo;

    localparam int DW    = 13;
    localparam int DEPTH = 16;

    logic          clk;
    logic          reset;
    logic          push, pop, flush, err_clr;
    logic [DW-1:0] din;
    logic [DW-1:0] top, peek_data;
    logic [3:0]    peek_idx;
    logic          peek_valid, empty, full, overflow, underflow;
    logic [4:0]    count;

    int checkCount = 0;
    int passCount  = 0;

    logic [DW-1:0] stack[$];
    bit            mOvf, mUdf;

    rstack_lifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IDX_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .flush(flush), .err_clr(err_clr), .top(top), .peek_idx(peek_idx),
        .peek_data(peek_data), .peek_valid(peek_valid), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Behavioural stack rules: a queue whose size is the count and whose back is the top.
    task automatic modelUpdate(input bit p, input bit q, input bit f, input bit e, input logic [DW-1:0] d);
        bit setO = 0, setU = 0;
        if (f) stack.delete();
        else if (p && !q) begin
            if (stack.size() < DEPTH) stack.push_back(d);
            else setO = 1;
        end else if (q && !p) begin
            if (stack.size() > 0) void'(stack.pop_back());
            else setU = 1;
        end else if (p && q) begin
            if (stack.size() > 0) stack[stack.size()-1] = d;
            else begin
                setU = 1;
                stack.push_back(d);
            end
        end
        mOvf = setO ? 1'b1 : (e ? 1'b0 : mOvf);
        mUdf = setU ? 1'b1 : (e ? 1'b0 : mUdf);
    endtask

    task automatic applyStimulus(input bit p, input bit q, input bit f, input bit e, input logic [DW-1:0] d);
        push = p; pop = q; flush = f; err_clr = e; din = d;
        @(posedge clk);
        modelUpdate(p, q, f, e, d);
        #1;
        push = 0; pop = 0; flush = 0; err_clr = 0;
    endtask

    task automatic checkAll(input string tag);
        int n = stack.size();
        int i = int'(peek_idx);
        logic [DW-1:0] expTop = (n > 0) ? stack[n-1] : '0;
        logic [DW-1:0] expPeek = (i < n) ? stack[n-1-i] : '0;
        checkOutput({tag, ".count"}, 32'(count), 32'(n));
        checkOutput({tag, ".top"}, 32'(top), 32'(expTop));
        checkOutput({tag, ".empty"}, 32'(empty), 32'(n == 0));
        checkOutput({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        checkOutput({tag, ".ovf"}, 32'(overflow), 32'(mOvf));
        checkOutput({tag, ".udf"}, 32'(underflow), 32'(mUdf));
        checkOutput({tag, ".pvalid"}, 32'(peek_valid), 32'(i < n));
        checkOutput({tag, ".pdata"}, 32'(peek_data), 32'(expPeek));
    endtask

    initial begin
        push = 0; pop = 0; flush = 0; err_clr = 0; din = '0; peek_idx = '0;
        reset = 1'b1;
        #22;
        reset = 1'b0;
        stack.delete(); mOvf = 0; mUdf = 0;
        checkAll("reset");

        // T1
        applyStimulus(1, 0, 0, 0, 13'h100);
        applyStimulus(1, 0, 0, 0, 13'h101);
        applyStimulus(1, 0, 0, 0, 13'h102);
        peek_idx = 4'd2;
        #1;
        checkOutput("t1.count", 32'(count), 32'd3);
        checkOutput("t1.top", 32'(top), 32'h102);
        checkOutput("t1.peek", 32'(peek_data), 32'h100);
        checkOutput("t1.pvalid", 32'(peek_valid), 32'd1);
        checkAll("t1");

        // T2
        applyStimulus(0, 0, 1, 0, '0);
        for (int k = 0; k < DEPTH; k++) applyStimulus(1, 0, 0, 0, DW'(k));
        checkOutput("t2.full", 32'(full), 32'd1);
        checkOutput("t2.top", 32'(top), 32'd15);
        applyStimulus(1, 0, 0, 0, 13'h1FFF);
        checkOutput("t2.ovfcount", 32'(count), 32'd16);
        checkOutput("t2.ovftop", 32'(top), 32'd15);
        checkOutput("t2.ovf", 32'(overflow), 32'd1);
        checkAll("t2.ovf");
        for (int k = DEPTH - 1; k >= 0; k--) begin
            checkOutput("t2.poptop", 32'(top), 32'(k));
            applyStimulus(0, 1, 0, 0, '0);
        end
        checkOutput("t2.empty", 32'(empty), 32'd1);

        // T3
        applyStimulus(0, 1, 0, 0, '0);
        checkOutput("t3.udf", 32'(underflow), 32'd1);
        checkOutput("t3.count", 32'(count), 32'd0);
        applyStimulus(0, 0, 0, 1, '0);
        checkOutput("t3.clr", 32'(underflow), 32'd0);
        checkOutput("t3.ovfclr", 32'(overflow), 32'd0);
        applyStimulus(1, 1, 0, 1, 13'h77);
        checkOutput("t3.setwins", 32'(underflow), 32'd1);
        checkAll("t3");

        // T4
        applyStimulus(0, 0, 1, 1, '0);
        for (int k = 0; k < DEPTH; k++) applyStimulus(1, 0, 0, 0, DW'(k + 32));
        applyStimulus(1, 1, 0, 0, 13'hAAA);
        checkOutput("t4.count", 32'(count), 32'd16);
        checkOutput("t4.top", 32'(top), 32'hAAA);
        checkOutput("t4.ovf", 32'(overflow), 32'd0);
        checkAll("t4.full");
        applyStimulus(0, 0, 1, 0, '0);
        applyStimulus(1, 1, 0, 0, 13'h5);
        checkOutput("t4.ecount", 32'(count), 32'd1);
        checkOutput("t4.etop", 32'(top), 32'h5);
        checkOutput("t4.eudf", 32'(underflow), 32'd1);

        // T5
        applyStimulus(0, 0, 1, 1, '0);
        applyStimulus(0, 1, 0, 0, '0);
        for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 0, DW'(k + 200));
        applyStimulus(1, 0, 1, 0, 13'h123);
        peek_idx = 4'd0;
        #1;
        checkOutput("t5.count", 32'(count), 32'd0);
        checkOutput("t5.top", 32'(top), 32'd0);
        checkOutput("t5.udfkept", 32'(underflow), 32'd1);
        checkOutput("t5.pvalid", 32'(peek_valid), 32'd0);
        checkOutput("t5.pdata", 32'(peek_data), 32'd0);
        checkAll("t5");

        // T6
        for (int k = 0; k < 7; k++) applyStimulus(1, 0, 0, 0, DW'(k + 300));
        checkOutput("t6.pre", 32'(count), 32'd7);
        reset = 1'b1;
        #2;
        stack.delete(); mOvf = 0; mUdf = 0;
        checkOutput("t6.count", 32'(count), 32'd0);
        checkOutput("t6.empty", 32'(empty), 32'd1);
        checkAll("t6");
        reset = 1'b0;

        // Random traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 400; i++) begin
            int r = int'($urandom_range(0, 99));
            bit pushHeavy = ((i / 50) % 2) == 0;
            bit p, q, f, e;
            f = (r < 3);
            e = ($urandom_range(0, 9) == 0);
            r = int'($urandom_range(0, 99));
            if (pushHeavy) begin
                p = (r < 75);
                q = (r >= 55 && r < 90);
            end else begin
                p = (r < 35);
                q = (r >= 20 && r < 95);
            end
            peek_idx = 4'($urandom_range(0, 15));
            applyStimulus(p, q, f, e, DW'($urandom));
            checkAll("rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
